// File: rtl/secded_scrubber.sv
// Background SECDED scrubber for a 39b {checksum, data} memory behind a shared req/gnt port.
// Rewrites single-bit errors corrected; counts and reports corrected and uncorrectable words.

package edac;
    // Column i of the H matrix is the i-th 7-bit weight-3 value in ascending order.
    localparam logic [6:0] H_COL [32] = '{
        7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
        7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
        7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
        7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
    };

    function automatic logic [6:0] edac_checksum(input logic [31:0] data);
        logic [6:0] chk;
        chk = '0;
        for (int i = 0; i < 32; i++) begin
            if (data[i]) chk = chk ^ H_COL[i];
        end
        return chk;
    endfunction
endpackage

module secded_scrubber #(
    parameter int DEPTH  = 1024,
    parameter int AW     = 10,
    parameter int PERIOD = 256,
    parameter int CNT_W  = 16
) (
    input  logic             s_clk_i,
    input  logic             s_resetn_i,
    input  logic             s_en_i,
    output logic             s_mreq_o,
    output logic             s_mwe_o,
    output logic [AW-1:0]    s_maddr_o,
    output logic [38:0]      s_mwdata_o,
    input  logic             s_mgnt_i,
    input  logic             s_mrvalid_i,
    input  logic [38:0]      s_mrdata_i,
    input  logic             s_clr_i,
    output logic [CNT_W-1:0] s_ce_cnt_o,
    output logic [CNT_W-1:0] s_ue_cnt_o,
    output logic             s_ue_o,
    output logic [AW-1:0]    s_ue_addr_o,
    output logic             s_pass_o,
    output logic             s_busy_o
);
    import edac::*;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RD, S_RWAIT, S_CHECK, S_WR, S_NEXT
    } state_t;

    localparam int              PW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0]   PCNT_LAST = PW'(PERIOD - 1);
    localparam logic [AW-1:0]   ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    logic [PW-1:0]    r_pcnt;
    logic [AW-1:0]    r_addr;
    logic             r_mreq;
    logic             r_mwe;
    logic [38:0]      r_mwdata;
    logic [38:0]      r_rword;
    logic [CNT_W-1:0] r_ce_cnt;
    logic [CNT_W-1:0] r_ue_cnt;
    logic             r_ue;
    logic [AW-1:0]    r_ue_addr;
    logic             r_pass;
    logic             r_busy;

    logic [31:0] w_data;
    logic [6:0]  w_syn;
    logic [31:0] w_flip;
    logic [31:0] w_cdata;
    logic [38:0] w_wword;
    logic        w_ce;
    logic        w_ue;

    assign w_data = r_rword[31:0];
    assign w_syn  = edac_checksum(w_data) ^ r_rword[38:32];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_flip = '0;
        for (int i = 0; i < 32; i++) begin
            w_flip[i] = (w_syn == H_COL[i]);
        end
    end

    // A weight-1 syndrome is a checkbit error: data is fine, only the checksum is rewritten.
    assign w_ce    = (|w_flip) || ($countones(w_syn) == 1);
    assign w_ue    = (w_syn != '0) && !w_ce;
    assign w_cdata = w_data ^ w_flip;
    assign w_wword = {edac_checksum(w_cdata), w_cdata};

    // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_state   <= S_IDLE;
            r_pcnt    <= '0;
            r_addr    <= '0;
            r_mreq    <= 1'b0;
            r_mwe     <= 1'b0;
            r_mwdata  <= '0;
            r_rword   <= '0;
            r_ce_cnt  <= '0;
            r_ue_cnt  <= '0;
            r_ue      <= 1'b0;
            r_ue_addr <= '0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ue <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (s_en_i) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!s_en_i) begin
                        r_state <= S_IDLE;
                        r_pcnt  <= '0;
                    end else if (r_pcnt == PCNT_LAST) begin
                        r_pcnt  <= '0;
                        r_state <= S_RD;
                        r_mreq  <= 1'b1;
                        r_mwe   <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_pcnt <= r_pcnt + PW'(1);
                    end
                end
                S_RD: begin
                    if (s_mgnt_i) begin
                        r_mreq  <= 1'b0;
                        r_state <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (s_mrvalid_i) begin
                        r_rword <= s_mrdata_i;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_ce) begin
                        if (r_ce_cnt != CNT_MAX) r_ce_cnt <= r_ce_cnt + CNT_W'(1);
                        r_mwdata <= w_wword;
                        r_mreq   <= 1'b1;
                        r_mwe    <= 1'b1;
                        r_state  <= S_WR;
                    end else begin
                        if (w_ue) begin
                            if (r_ue_cnt != CNT_MAX) r_ue_cnt <= r_ue_cnt + CNT_W'(1);
                            r_ue      <= 1'b1;
                            r_ue_addr <= r_addr;
                        end
                        r_state <= S_NEXT;
                    end
                end
                S_WR: begin
                    if (s_mgnt_i) begin
                        r_mreq  <= 1'b0;
                        r_mwe   <= 1'b0;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_addr == ADDR_LAST) begin
                        r_addr <= '0;
                        r_pass <= 1'b1;
                    end else begin
                        r_addr <= r_addr + AW'(1);
                    end
                    r_busy  <= 1'b0;
                    r_state <= s_en_i ? S_WAIT : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // Placed last so a clear overrides any increment or pass flag set this same cycle.
            if (s_clr_i) begin
                r_ce_cnt <= '0;
                r_ue_cnt <= '0;
                r_pass   <= 1'b0;
            end
        end
    end

    assign s_mreq_o    = r_mreq;
    assign s_mwe_o     = r_mwe;
    assign s_maddr_o   = r_addr;
    assign s_mwdata_o  = r_mwdata;
    assign s_ce_cnt_o  = r_ce_cnt;
    assign s_ue_cnt_o  = r_ue_cnt;
    assign s_ue_o      = r_ue;
    assign s_ue_addr_o = r_ue_addr;
    assign s_pass_o    = r_pass;
    assign s_busy_o    = r_busy;

endmodule

// File: tb/tb_secded_scrubber.sv
// Scoreboard bench for secded_scrubber: a memory responder with random grant/latency, a
// brute-force SECDED reference (try every single-bit flip) and a decoupled output monitor.

module tb_secded_scrubber;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int PERIOD = 3;
    localparam int CNT_W  = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n, en, mgnt, mrvalid, clr;
    logic [38:0] mrdata;
    logic mreq, mwe, ue_o, pass, busy;
    logic [AW-1:0] maddr, ue_addr;
    logic [38:0] mwdata;
    logic [CNT_W-1:0] ce_cnt, ue_cnt;

    always #5 clk = ~clk;

    secded_scrubber #(.DEPTH(DEPTH), .AW(AW), .PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
        .s_clk_i(clk), .s_resetn_i(rst_n), .s_en_i(en),
        .s_mreq_o(mreq), .s_mwe_o(mwe), .s_maddr_o(maddr), .s_mwdata_o(mwdata),
        .s_mgnt_i(mgnt), .s_mrvalid_i(mrvalid), .s_mrdata_i(mrdata), .s_clr_i(clr),
        .s_ce_cnt_o(ce_cnt), .s_ue_cnt_o(ue_cnt), .s_ue_o(ue_o), .s_ue_addr_o(ue_addr),
        .s_pass_o(pass), .s_busy_o(busy)
    );

    typedef struct {
        bit          ue;
        logic [AW-1:0] addr;
        logic [38:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [38:0] mem [DEPTH];
    logic [6:0]  cols [32];
    int          n_vec = 0;
    int          n_fail = 0;
    int          exp_ce, exp_ue;
    logic [AW-1:0] exp_addr;
    bit          exp_pass;
    bit          fast, rd_pend;
    int          stall_wr, force_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void build_cols();
        int k = 0;
        for (int v = 0; v < 128; v++) begin
            if ($countones(v) == 3 && k < 32) begin
                cols[k] = 7'(v);
                k++;
            end
        end
    endfunction

    function automatic logic [6:0] cs(input logic [31:0] d);
        logic [6:0] c = '0;
        for (int i = 0; i < 32; i++) if (d[i]) c ^= cols[i];
        return c;
    endfunction

    function automatic bit valid(input logic [38:0] w);
        return cs(w[31:0]) == w[38:32];
    endfunction

    // 0 = clean, 1 = correctable (fixed = nearest codeword), 2 = uncorrectable.
    function automatic int classify(input logic [38:0] w, output logic [38:0] fixed);
        logic [38:0] t;
        fixed = w;
        if (valid(w)) return 0;
        for (int b = 0; b < 39; b++) begin
            t = w ^ (39'(1) << b);
            if (valid(t)) begin
                fixed = t;
                return 1;
            end
        end
        return 2;
    endfunction

    task automatic responder();
        logic [38:0] rd_word, fixed;
        logic [AW-1:0] snap_addr;
        logic snap_we;
        logic [38:0] snap_wd;
        bit snap_v = 0;
        int lat = 0;
        int kind;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_addr = '0;
                exp_pass = 0;
                snap_v = 0;
            end
            mrvalid = 1'b0;
            if (rd_pend) begin
                lat--;
                if (lat <= 0) begin
                    mrvalid = 1'b1;
                    mrdata  = rd_word;
                    rd_pend = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mrvalid = 1'b1;
                mrdata  = {7'($urandom), $urandom};
            end
            mgnt = 1'b0;
            if (rst_n && snap_v) begin
                check("req_held", mreq, 1);
                check("req_addr_stable", maddr, snap_addr);
                check("req_we_stable", mwe, snap_we);
                check("req_wdata_stable", mwdata, snap_wd);
            end
            if (rst_n && mreq) begin
                if (!snap_v) begin
                    snap_v = 1;
                    snap_addr = maddr;
                    snap_we = mwe;
                    snap_wd = mwdata;
                end
                if (mwe && stall_wr > 0) stall_wr--;
                else if (!mwe && rd_pend) mgnt = 1'b0;
                else mgnt = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
                if (mgnt) begin
                    snap_v = 0;
                    if (mwe) begin
                        mem[maddr] = mwdata;
                    end else begin
                        check("rd_addr", maddr, exp_addr);
                        check("rd_pass", pass, exp_pass);
                        check("rd_queue_drained", exp_q.size(), 0);
                        rd_word = mem[maddr];
                        kind = classify(rd_word, fixed);
                        if (kind != 0) begin
                            e.ue = (kind == 2);
                            e.addr = maddr;
                            e.word = fixed;
                            exp_q.push_back(e);
                        end
                        if (exp_addr == AW'(DEPTH - 1)) begin
                            exp_addr = '0;
                            exp_pass = 1;
                        end else begin
                            exp_addr = exp_addr + 1'b1;
                        end
                        rd_pend = 1;
                        lat = (force_lat > 0) ? force_lat : (fast ? 1 : $urandom_range(1, 3));
                    end
                end
            end else if (!mreq) begin
                mgnt = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                exp_q.delete();
                exp_ce = 0;
                exp_ue = 0;
            end else begin
                if (mreq && mwe && mgnt) begin
                    check("wr_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("wr_is_ce", e.ue, 0);
                        check("wr_addr", maddr, e.addr);
                        check("wr_data", mwdata, e.word);
                        if (exp_ce < CMAX) exp_ce++;
                        check("ce_cnt", ce_cnt, exp_ce);
                    end
                end
                if (ue_o) begin
                    check("ue_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("ue_is_ue", e.ue, 1);
                        check("ue_addr", ue_addr, e.addr);
                        if (exp_ue < CMAX) exp_ue++;
                        check("ue_cnt", ue_cnt, exp_ue);
                    end
                end
            end
        end
    endtask

    task automatic wait_busy(input logic lvl, input int budget, output int n);
        n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("busy_timeout", busy, lvl);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mreq"}, mreq, 0);
        check({tag, "_mwe"}, mwe, 0);
        check({tag, "_maddr"}, maddr, 0);
        check({tag, "_ce_cnt"}, ce_cnt, 0);
        check({tag, "_ue_cnt"}, ue_cnt, 0);
        check({tag, "_ue"}, ue_o, 0);
        check({tag, "_ue_addr"}, ue_addr, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [38:0] orig3, orig4, bad6;
        int n, a, nf;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mgnt = 1'b0; mrvalid = 1'b0; mrdata = '0;
        fast = 1; rd_pend = 0; stall_wr = 0; force_lat = 0;
        exp_ce = 0; exp_ue = 0; exp_addr = '0; exp_pass = 0;
        build_cols();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        check("reset_mwdata", mwdata, 0);

        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] d;
            d = $urandom;
            mem[i] = {cs(d), d};
        end
        mem[5] = {cs(32'hDEADBEEF), 32'hDEADBEEF};
        orig3 = mem[3];
        mem[3][7] = ~mem[3][7];
        orig4 = mem[4];
        mem[4][34] = ~mem[4][34];
        mem[6][0] = ~mem[6][0];
        mem[6][31] = ~mem[6][31];
        bad6 = mem[6];

        rst_n = 1'b1;
        fork
            responder();
            monitor();
        join_none

        // Directed pass: 0-wait grants, 1-cycle read latency.
        en = 1'b1;
        wait_busy(1'b1, 50, n);
        wait_busy(1'b0, 50, n);
        check("clean_word_busy_cycles", n, 4);
        wait_busy(1'b1, 50, n);
        check("wait_period_cycles", n, PERIOD);
        stall_wr = 20;
        n = 0;
        while (!pass && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("pass_reached", pass, 1);
        check("pass1_ce_cnt", ce_cnt, 2);
        check("pass1_ue_cnt", ue_cnt, 1);
        check("pass1_ue_addr", ue_addr, 6);
        check("mem3_corrected", mem[3], orig3);
        check("mem4_checksum_fixed", mem[4], orig4);
        check("mem5_untouched", mem[5], {cs(32'hDEADBEEF), 32'hDEADBEEF});
        check("mem6_not_written", mem[6], bad6);
        check("stall_consumed", stall_wr, 0);

        en = 1'b0;
        repeat (30) @(negedge clk);
        check("stopped_idle", busy, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_ce = 0;
        exp_ue = 0;
        exp_pass = 0;
        check("clr_ce_cnt", ce_cnt, 0);
        check("clr_ue_cnt", ue_cnt, 0);
        check("clr_pass", pass, 0);

        // Random phase: random grants/latency, error injection, enable toggling.
        fast = 0;
        en = 1'b1;
        for (int it = 0; it < 150; it++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, DEPTH - 1);
                nf = $urandom_range(1, 3);
                for (int k = 0; k < nf; k++) mem[a][$urandom_range(0, 38)] ^= 1'b1;
            end
            en = ($urandom_range(0, 9) != 0);
        end
        en = 1'b1;
        repeat (60) @(negedge clk);
        check("rand_ce_cnt", ce_cnt, exp_ce);
        check("rand_ue_cnt", ue_cnt, exp_ue);

        // Reset while a read is outstanding; the late rvalid must be ignored.
        force_lat = 6;
        n = 0;
        while (!rd_pend && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rd_outstanding", rd_pend, 1);
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check_zero_outputs("midrd_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        force_lat = 0;
        n = 0;
        while (rd_pend && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("late_rvalid_ignored_busy", busy, 0);
        check("late_rvalid_ignored_addr", maddr, 0);
        fast = 1;
        en = 1'b1;
        repeat (40) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        check("final_ce_cnt", ce_cnt, exp_ce);
        check("final_ue_cnt", ue_cnt, exp_ue);
        check("final_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
